// File: rtl/door_pkg.sv
// Shared constants and the press-direction decode for the garage door command stage.
package door_pkg;

    localparam int DEF_DEBOUNCE_CYCLES  = 4;
    localparam int DEF_AUTOCLOSE_CYCLES = 200;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_OPEN  = 2'd1;
    localparam logic [1:0] CMD_CLOSE = 2'd2;

    // Moving up or fully open reverses to close; moving down or fully closed opens;
    // a door stopped mid-travel closes.
    function automatic logic [1:0] decode_press(
        input logic power_up,
        input logic door_up,
        input logic power_down,
        input logic door_down
    );
        logic [1:0] cmd;
        if (power_up || door_up) begin
            cmd = CMD_CLOSE;
        end else if (power_down || door_down) begin
            cmd = CMD_OPEN;
        end else begin
            cmd = CMD_CLOSE;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability counter; emits a registered pulse on each
// debounced rising edge.
module button_debouncer
    import door_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic rise_pulse
);

    logic       sync1_r;
    logic       btn_s;
    logic [7:0] cnt_r;
    logic       deb_r;
    logic       rise_r;

    // Synchronise, then accept the new level only after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b0;
            btn_s   <= 1'b0;
            cnt_r   <= 8'd0;
            deb_r   <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            sync1_r <= raw_in;
            btn_s   <= sync1_r;
            rise_r  <= 1'b0;
            if (btn_s != deb_r) begin
                if (cnt_r == 8'(DEBOUNCE_CYCLES - 1)) begin
                    deb_r  <= btn_s;
                    cnt_r  <= 8'd0;
                    rise_r <= btn_s;
                end else begin
                    cnt_r <= cnt_r + 8'd1;
                end
            end else begin
                cnt_r <= 8'd0;
            end
        end
    end

    assign level      = deb_r;
    assign rise_pulse = rise_r;

endmodule

// File: rtl/door_command_ctrl.sv
// Turns a debounced button, obstruction sensor and auto-close timer into one-cycle
// open/close command pulses for the garage door controller.
module door_command_ctrl
    import door_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int AUTOCLOSE_CYCLES = DEF_AUTOCLOSE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    input  logic obstruction,
    input  logic autoclose_en,
    input  logic door_up,
    input  logic door_down,
    input  logic power_up,
    input  logic power_down,
    output logic open,
    output logic close,
    output logic autoclose_pending
);

    logic        level_s;
    logic        rise_s;
    logic        press_s;
    logic [1:0]  press_cmd_s;
    logic [1:0]  cmd_s;
    logic        ac_run_s;
    logic        ac_fire_s;
    logic [15:0] ac_cnt_r;
    logic [15:0] ac_cnt_next_s;
    logic        open_r;
    logic        close_r;
    logic        pending_r;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock      (clock),
        .reset      (reset),
        .raw_in     (button),
        .level      (level_s),
        .rise_pulse (rise_s)
    );

    assign press_s     = rise_s & level_s;
    assign press_cmd_s = decode_press(power_up, door_up, power_down, door_down);
    assign ac_run_s    = autoclose_en & door_up & ~power_down & ~obstruction;
    assign ac_fire_s   = ac_run_s && (ac_cnt_r == 16'(AUTOCLOSE_CYCLES - 1));

    // Command arbitration: obstruction reopen beats a press, which beats auto-close.
    always_comb begin
        cmd_s = CMD_NONE;
        if (obstruction && power_down) begin
            cmd_s = CMD_OPEN;
        end else if (press_s) begin
            cmd_s = (obstruction && (press_cmd_s == CMD_CLOSE)) ? CMD_NONE : press_cmd_s;
        end else if (ac_fire_s) begin
            cmd_s = CMD_CLOSE;
        end else begin
            cmd_s = CMD_NONE;
        end
    end

    // Auto-close counter restarts on any press, on firing, or when the door leaves the open rest state.
    always_comb begin
        ac_cnt_next_s = 16'd0;
        if (press_s || !ac_run_s || ac_fire_s) begin
            ac_cnt_next_s = 16'd0;
        end else begin
            ac_cnt_next_s = ac_cnt_r + 16'd1;
        end
    end

    // Registered command pulses and auto-close state.
    always_ff @(posedge clock) begin
        if (reset) begin
            open_r    <= 1'b0;
            close_r   <= 1'b0;
            pending_r <= 1'b0;
            ac_cnt_r  <= 16'd0;
        end else begin
            open_r    <= (cmd_s == CMD_OPEN);
            close_r   <= (cmd_s == CMD_CLOSE);
            pending_r <= (ac_cnt_next_s != 16'd0);
            ac_cnt_r  <= ac_cnt_next_s;
        end
    end

    assign open              = open_r;
    assign close             = close_r;
    assign autoclose_pending = pending_r;

endmodule
